// File: rtl/fnd_scan_display.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// The value is latched once per frame, with optional leading-zero blanking, a per-digit dp and an enable.
module fnd_scan_display #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  dp,
  input  logic        en,
  output logic [3:0]  com,
  output logic [7:0]  seg_7,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [15:0]      disp_q, disp_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       seg_q, seg_d;
  logic             frame_tick_q, frame_tick_d;

  logic             tick;
  logic             wrap;
  logic [3:0]       nib;
  logic [3:0]       lz;
  logic             blank;

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    wrap  = tick && (idx_q == 2'd3);

    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    pend_d = load ? value : pend_q;

    // A load landing on the wrap tick bypasses pend and goes straight to disp.
    disp_d   = disp_q;
    pend_v_d = pend_v_q;
    if (wrap) begin
      pend_v_d = 1'b0;
      if (load) begin
        disp_d = value;
      end else if (pend_v_q) begin
        disp_d = pend_q;
      end
    end else if (load) begin
      pend_v_d = 1'b1;
    end

    case (idx_d)
      2'd0:    nib = disp_d[3:0];
      2'd1:    nib = disp_d[7:4];
      2'd2:    nib = disp_d[11:8];
      default: nib = disp_d[15:12];
    endcase

    // lz[k] = nibbles k..3 of the frame's value are all zero; digit 0 is never blanked.
    lz[3] = (disp_d[15:12] == 4'h0);
    lz[2] = lz[3] && (disp_d[11:8] == 4'h0);
    lz[1] = lz[2] && (disp_d[7:4] == 4'h0);
    lz[0] = 1'b0;
    blank = blank_lz && lz[idx_d];

    com_d = 4'b1111;
    seg_d = 8'hFF;
    if (en) begin
      com_d = ~(4'b0001 << idx_d);
      seg_d = {~dp[idx_d], blank ? 7'h7F : hex_to_seg(nib)};
    end

    frame_tick_d = wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      pend_q       <= 16'h0000;
      pend_v_q     <= 1'b0;
      disp_q       <= 16'h0000;
      com_q        <= 4'b1110;
      seg_q        <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      disp_q       <= disp_d;
      com_q        <= com_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign com        = com_q;
  assign seg_7      = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_fnd_scan_display.sv
// Bench for fnd_scan_display with SCAN_DIV=4, checked each cycle against a frame-level model.
module tb_fnd_scan_display;

  logic        clk;
  logic        reset_n;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp;
  logic        en;
  logic [3:0]  com;
  logic [7:0]  seg_7;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  fnd_scan_display #(.SCAN_DIV(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .dp         (dp),
    .en         (en),
    .com        (com),
    .seg_7      (seg_7),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
  end

  // Model: m_pos counts enabled cycles since reset; slot = pos/4, digit = slot%4.
  int          m_pos;
  logic [15:0] m_pend;
  logic        m_pendv;
  logic [15:0] m_disp;
  logic [3:0]  m_com;
  logic [7:0]  m_seg;
  logic        m_ft;

  task automatic model_reset();
    m_pos = 0; m_pend = 16'h0; m_pendv = 1'b0; m_disp = 16'h0;
    m_com = 4'b1110; m_seg = 8'hFF; m_ft = 1'b0;
  endtask

  function automatic bit wrap_next();
    return en && (m_pos % 4 == 3) && ((m_pos / 4) % 4 == 3);
  endfunction

  // Advance DUT and model by one clock; outputs settle #1 after the edge.
  task automatic cyc();
    bit tk, wr, blk;
    int pos_n, d;
    logic [15:0] nd, np;
    logic        npv;
    logic [3:0]  ncom;
    logic [7:0]  nseg;
    tk    = en && (m_pos % 4 == 3);
    wr    = tk && ((m_pos / 4) % 4 == 3);
    pos_n = en ? m_pos + 1 : m_pos;
    d     = (pos_n / 4) % 4;
    nd    = m_disp;
    if (wr && load) nd = value;
    else if (wr && m_pendv) nd = m_pend;
    npv = wr ? 1'b0 : (load ? 1'b1 : m_pendv);
    np  = load ? value : m_pend;
    blk = blank_lz && (d != 0) && ((nd >> (4 * d)) == 16'h0);
    if (en) begin
      ncom = 4'hF ^ (4'(1) << d);
      nseg = {~dp[d], blk ? 7'h7F : seg_tab[(nd >> (4 * d)) & 16'hF]};
    end else begin
      ncom = 4'hF;
      nseg = 8'hFF;
    end
    @(posedge clk);
    #1;
    m_pos = pos_n; m_disp = nd; m_pend = np; m_pendv = npv;
    m_com = ncom; m_seg = nseg; m_ft = wr;
  endtask

  task automatic test_reset();
    int ft_cnt;
    reset_n = 1'b0; value = 16'h0; load = 1'b0; blank_lz = 1'b0; dp = 4'h0; en = 1'b1;
    model_reset();
    #23;
    total++;
    if (com !== 4'b1110 || seg_7 !== 8'hFF || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: com=%b seg=%h ft=%b, want com=1110 seg=ff ft=0", com, seg_7, frame_tick);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ft_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      if (frame_tick) ft_cnt++;
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL reset_scan cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
    end
    total++;
    if (ft_cnt !== 2) begin
      bad++;
      $display("FAIL frame_tick_count: got %0d want 2", ft_cnt);
    end
  endtask

  task automatic test_load_frame();
    bit seen;
    for (int i = 0; i < 6; i++) cyc();
    value = 16'h12AF; load = 1'b1;
    cyc();
    load = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL load_frame cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
      if (m_ft && !seen) begin
        seen = 1'b1;
        total++;
        if (com !== 4'b1110 || seg_7 !== 8'b1_0001110) begin
          bad++;
          $display("FAIL load_first_digit0: com=%b seg=%b want 1110 10001110", com, seg_7);
        end
      end
    end
  endtask

  task automatic test_blank();
    blank_lz = 1'b1;
    value = 16'h0005; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL blank_0005 cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
      if (m_com == 4'b1110 && i > 20) begin
        total++;
        if (seg_7 !== 8'b1_0010010) begin
          bad++;
          $display("FAIL blank_digit0_5: seg=%b want 10010010", seg_7);
        end
      end
    end
    value = 16'h0000; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL blank_0000 cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
      if (m_com == 4'b1110 && i > 20) begin
        total++;
        if (seg_7 !== 8'b1_1000000) begin
          bad++;
          $display("FAIL blank_digit0_0: seg=%b want 11000000", seg_7);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) cyc();
    value = 16'h1111; load = 1'b1; cyc();
    load = 1'b0; cyc();
    value = 16'h2222; load = 1'b1; cyc();
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL two_loads cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
    end
    for (int i = 0; i < 20 && !wrap_next(); i++) cyc();
    total++;
    if (!wrap_next()) begin
      bad++;
      $display("FAIL wrap_search: no wrap tick within budget");
    end
    value = 16'h3333; load = 1'b1;
    cyc();
    load = 1'b0;
    total++;
    if (com !== 4'b1110 || seg_7 !== 8'b1_0110000 || frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL load_on_wrap: com=%b seg=%b ft=%b want 1110 10110000 1", com, seg_7, frame_tick);
    end
    for (int i = 0; i < 32; i++) begin
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL after_wrap_load cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
    end
  endtask

  task automatic test_dp_enable();
    dp = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL dp cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
    end
    for (int i = 0; i < 8 && (m_pos % 4 != 1); i++) cyc();
    en = 1'b0;
    cyc();
    total++;
    if (com !== 4'b1111 || seg_7 !== 8'hFF) begin
      bad++;
      $display("FAIL en_off: com=%b seg=%h want 1111 ff", com, seg_7);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL en_hold cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL en_resume cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
    end
    dp = 4'h0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) value[7:4] = 4'h0;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL random cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
    end
    load = 1'b0; en = 1'b1; dp = 4'h0; blank_lz = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) cyc();
    value = 16'hBEEF; load = 1'b1; cyc();
    load = 1'b0;
    cyc();
    cyc();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (com !== 4'b1110 || seg_7 !== 8'hFF || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: com=%b seg=%h ft=%b want 1110 ff 0", com, seg_7, frame_tick);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if (com !== m_com || seg_7 !== m_seg || frame_tick !== m_ft) begin
        bad++;
        $display("FAIL post_reset cyc%0d: com=%b/%b seg=%h/%h ft=%b/%b (got/want)",
                 i, com, m_com, seg_7, m_seg, frame_tick, m_ft);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_frame();
    test_blank();
    test_back_to_back();
    test_dp_enable();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
